seven_segment_scanner: RTL and testbench



---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_decoder.sv | 35 +++
 rtl/seven_segment_scanner.sv | 152 +++++++++++++++
 tb/tb_seven_segment_scanner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the seven-segment scanner.
// Patterns are {a,b,c,d,e,f,g}, active-high, segment a in the MSB.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble to seven-segment decoder.
// SEG7_HEX_EN selects hex glyphs for 10..15; otherwise those values show blank.
module seg7_decoder
  import seg7_pkg::*;
(
  input  nibble_t value,
  output seg_t    seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
`ifdef SEG7_HEX_EN
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
`endif
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver with a tear-free display register.
// Hex glyphs for 10..15 are enabled by defining SEG7_HEX_EN (see seg7_decoder).
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_blank,
  output seg_t                  seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                tick, frame_end;

  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_v_q, pend_v_d;
  logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;

  nibble_t             digit_arr [DIGITS];
  nibble_t             cur_val;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_above;
  logic                blank;
  seg_t                dec_seg;
  logic [DIGITS-1:0]   an_d;

  seg_t                seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   an_q;
  logic                frame_end_q;
  logic                frame_done_q;

  // Prescaler and digit index
  always_comb begin
    tick      = (cnt_q == CntMax);
    frame_end = tick && (idx_q == IdxMax);
    cnt_d     = tick ? '0 : cnt_q + CntW'(1);
    idx_d     = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
    end
  end

  // A load only reaches the display at a frame boundary, so a frame never mixes values.
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_v_d    = pend_v_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    if (frame_end) begin
      if (load) begin
        disp_data_d = data;
        disp_dp_d   = dp_in;
      end else if (pend_v_q) begin
        disp_data_d = pend_data_q;
        disp_dp_d   = pend_dp_q;
      end
      pend_v_d = 1'b0;
    end else if (load) begin
      pend_data_d = data;
      pend_dp_d   = dp_in;
      pend_v_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_v_q    <= 1'b0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_v_q    <= pend_v_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
    end
  end

  // lz_mask[i]: digit i and every digit above it are zero; digit 0 is never blanked.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      digit_arr[i] = disp_data_q[4*i +: 4];
    end
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above && (digit_arr[i] == 4'h0);
      lz_mask[i] = zero_above;
    end
    lz_mask[0] = 1'b0;
  end

  always_comb begin
    cur_val     = digit_arr[idx_q];
    blank       = lz_blank && lz_mask[idx_q];
    an_d        = '0;
    an_d[idx_q] = 1'b1;
  end

  seg7_decoder u_dec (
    .value (cur_val),
    .seg   (dec_seg)
  );

  // frame_done is delayed twice so it lines up with the first digit-0 slot on an.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b0;
      an_q         <= '0;
      frame_end_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= blank ? SEG_BLANK : dec_seg;
      dp_q         <= disp_dp_q[idx_q];
      an_q         <= an_d;
      frame_end_q  <= frame_end;
      frame_done_q <= frame_end_q;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (DIGITS=4, REFRESH_DIV=4).
// Expected outputs come from a frame-level model: each frame shows the last value loaded in the
// window ending at its start edge.
module tb_seven_segment_scanner;

  localparam int D  = 4;
  localparam int RD = 4;
  localparam int F  = D * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .DIGITS      (D),
    .REFRESH_DIV (RD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .dp_in      (dp_in),
    .load       (load),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  int          checks = 0;
  int          failures = 0;
  int          k;
  logic [15:0] fv [int];
  logic [3:0]  fvdp [int];
  logic [15:0] nxt;
  logic [3:0]  nxt_dp;
  bit          nxt_has;
  logic [6:0]  pat [16];
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_fd;

  task automatic reset_model();
    k = 0;
    fv.delete();
    fvdp.delete();
    fv[0]   = '0;
    fvdp[0] = '0;
    nxt_has = 1'b0;
  endtask

  // One clock edge k; computes expected outputs seen after that edge.
  task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] p);
    int          f;
    int          dig;
    logic [15:0] v;
    logic [3:0]  nib;
    load  = ld;
    data  = d;
    dp_in = p;
    @(posedge clk);
    k++;
    if (ld) begin
      nxt     = d;
      nxt_dp  = p;
      nxt_has = 1'b1;
    end
    if (k % F == 0) begin
      fv[k/F]   = nxt_has ? nxt : fv[k/F-1];
      fvdp[k/F] = nxt_has ? nxt_dp : fvdp[k/F-1];
      nxt_has   = 1'b0;
    end
    f       = (k - 1) / F;
    dig     = ((k - 1) / RD) % D;
    v       = fv[f];
    nib     = 4'((v >> (4 * dig)) & 16'hF);
    exp_an  = 4'(1 << dig);
    exp_seg = (lz_blank && dig != 0 && (v >> (4 * dig)) == 16'h0) ? 7'h00 : pat[nib];
    exp_dp  = fvdp[f][dig];
    exp_fd  = ((k - 1) % F == 0) && (k - 1 >= F);
    #1;
    load = 1'b0;
  endtask

  task automatic advance_to(input int phase);
    while (k % F != phase) step(1'b0, 16'h0, 4'h0);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'h0;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (an !== 4'b0000 || seg !== 7'b0000000 || dp !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state an=%b seg=%b dp=%b fd=%b required all zero", an, seg, dp, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    step(1'b0, 16'h0, 4'h0);
    checks++;
    if (an !== 4'b0001 || seg !== 7'b1111110) begin
      failures++;
      $display("FAIL first_edge an=%b/0001 seg=%b/1111110", an, seg);
    end
    for (int i = 0; i < 2 * F + 2; i++) begin
      step(1'b0, 16'h0, 4'h0);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_done !== exp_fd) begin
        failures++;
        $display("FAIL idle_scan k=%0d an=%b/%b seg=%b/%b dp=%b/%b fd=%b/%b",
                 k, an, exp_an, seg, exp_seg, dp, exp_dp, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_load_midframe();
    advance_to(5);
    step(1'b1, 16'h1295, 4'($urandom_range(15)));
    for (int i = 0; i < 2 * F; i++) begin
      step(1'b0, 16'h0, 4'h0);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_done !== exp_fd) begin
        failures++;
        $display("FAIL load_midframe k=%0d an=%b/%b seg=%b/%b dp=%b/%b fd=%b/%b",
                 k, an, exp_an, seg, exp_seg, dp, exp_dp, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_back_to_back();
    advance_to(2);
    step(1'b1, 16'h1111, 4'h1);
    step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h2222, 4'h2);
    advance_to(3);
    step(1'b1, 16'h1111, 4'h5);
    advance_to(F - 1);
    step(1'b1, 16'h4321, 4'ha);
    for (int i = 0; i < 2 * F; i++) begin
      step(1'b0, 16'h0, 4'h0);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_done !== exp_fd) begin
        failures++;
        $display("FAIL back_to_back k=%0d an=%b/%b seg=%b/%b dp=%b/%b fd=%b/%b",
                 k, an, exp_an, seg, exp_seg, dp, exp_dp, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_lz_blank();
    lz_blank = 1'b1;
    step(1'b1, 16'h0040, 4'h0);
    for (int i = 0; i < 3 * F; i++) begin
      if (i == 2 * F + 6) lz_blank = 1'b0;
      step(1'b0, 16'h0, 4'h0);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_done !== exp_fd) begin
        failures++;
        $display("FAIL lz_blank k=%0d lz=%b an=%b/%b seg=%b/%b dp=%b/%b fd=%b/%b",
                 k, lz_blank, an, exp_an, seg, exp_seg, dp, exp_dp, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_hex();
    step(1'b1, 16'h00AF, 4'h3);
    for (int i = 0; i < 2 * F; i++) begin
      step(1'b0, 16'h0, 4'h0);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_done !== exp_fd) begin
        failures++;
        $display("FAIL hex k=%0d an=%b/%b seg=%b/%b dp=%b/%b fd=%b/%b",
                 k, an, exp_an, seg, exp_seg, dp, exp_dp, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12 * F; i++) begin
      if ($urandom_range(9) == 0) lz_blank = ~lz_blank;
      step($urandom_range(7) == 0, rand_digits(), 4'($urandom_range(15)));
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_done !== exp_fd) begin
        failures++;
        $display("FAIL random k=%0d an=%b/%b seg=%b/%b dp=%b/%b fd=%b/%b",
                 k, an, exp_an, seg, exp_seg, dp, exp_dp, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_reset_midslot();
    lz_blank = 1'b0;
    advance_to(1);
    step(1'b1, 16'h7777, 4'hf);
    advance_to(2 * RD + 2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'b0000 || seg !== 7'b0000000 || dp !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_midslot an=%b seg=%b dp=%b fd=%b required all zero", an, seg, dp, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    for (int i = 0; i < 2 * F; i++) begin
      step(1'b0, 16'h0, 4'h0);
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_done !== exp_fd) begin
        failures++;
        $display("FAIL after_reset k=%0d an=%b/%b seg=%b/%b dp=%b/%b fd=%b/%b",
                 k, an, exp_an, seg, exp_seg, dp, exp_dp, frame_done, exp_fd);
      end
    end
  endtask

  initial begin
    pat[0]  = 7'b1111110; pat[1]  = 7'b0110000; pat[2]  = 7'b1101101; pat[3]  = 7'b1111001;
    pat[4]  = 7'b0110011; pat[5]  = 7'b1011011; pat[6]  = 7'b1011111; pat[7]  = 7'b1110000;
    pat[8]  = 7'b1111111; pat[9]  = 7'b1111011;
`ifdef SEG7_HEX_EN
    pat[10] = 7'b1110111; pat[11] = 7'b0011111; pat[12] = 7'b1001110; pat[13] = 7'b0111101;
    pat[14] = 7'b1001111; pat[15] = 7'b1000111;
`else
    for (int i = 10; i < 16; i++) pat[i] = 7'b0000000;
`endif
    reset_model();
    test_reset();
    test_load_midframe();
    test_back_to_back();
    test_lz_blank();
    test_hex();
    test_random();
    test_reset_midslot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
